// File: rtl/clock_pkg.sv
// Shared adjust-state encoding for the clock datapath: sequencer, field
// counters and display drivers all agree on these codes.
package clock_pkg;

  localparam int unsigned ADJ_NORM = 32'd0;

  // idx code that selects field f
  function automatic int unsigned adj_code(input int unsigned f);
    return f + 32'd1;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Single-bit rising-edge detector. The history flop resets high so a level
// that is already asserted when reset releases never reports an edge.
module edge_detect (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic rise
);

  logic prev_r;

  // previous-value history of the input
  always_ff @(posedge CLK) begin
    if (RST) begin
      prev_r <= 1'b1;
    end else begin
      prev_r <= d;
    end
  end

  assign rise = d & ~prev_r;

endmodule

// File: rtl/adjust_sequencer.sv
// Time-setting controller: walks NORM -> field 0 .. NFIELD-1 on MODE, issues
// per-field increment/clear strobes, auto-repeat, blink and idle timeout.
module adjust_sequencer
  import clock_pkg::*;
#(
  parameter int NFIELD     = 3,
  parameter int TOUT_TICKS = 60,
  parameter int REP_DELAY  = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SIG2HZ,
  input  logic              MODE,
  input  logic              SELECT,
  input  logic              ADJUST,
  output logic [NFIELD-1:0] CLR,
  output logic [NFIELD-1:0] INC,
  output logic [NFIELD-1:0] ON,
  output logic              ADJMODE
);

  localparam int IDX_W  = $clog2(NFIELD + 1);
  localparam int TOUT_W = (TOUT_TICKS > 0) ? $clog2(TOUT_TICKS + 1) : 1;
  localparam int REP_W  = (REP_DELAY > 0) ? $clog2(REP_DELAY + 1) : 1;

  localparam logic [IDX_W-1:0]  IDX_NORM  = IDX_W'(ADJ_NORM);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(adj_code(NFIELD - 1));
  localparam logic [TOUT_W-1:0] TOUT_LAST = (TOUT_TICKS > 0) ? TOUT_W'(TOUT_TICKS - 1) : {TOUT_W{1'b0}};
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REP_DELAY);

  logic mode_rise_s, sel_rise_s, adj_rise_s, tick_s;

  logic [IDX_W-1:0]  idx_r, idx_nxt_s;
  logic [REP_W-1:0]  rep_r, rep_nxt_s;
  logic [TOUT_W-1:0] idle_r, idle_nxt_s;
  logic [NFIELD-1:0] inc_r, inc_nxt_s, clr_r, clr_nxt_s, field_oh_s;
  logic              in_field_s, timeout_s, rep_fire_s, strobe_ok_s;

  edge_detect u_mode_ed (.CLK(CLK), .RST(RST), .d(MODE),   .rise(mode_rise_s));
  edge_detect u_sel_ed  (.CLK(CLK), .RST(RST), .d(SELECT), .rise(sel_rise_s));
  edge_detect u_adj_ed  (.CLK(CLK), .RST(RST), .d(ADJUST), .rise(adj_rise_s));
  edge_detect u_tick_ed (.CLK(CLK), .RST(RST), .d(SIG2HZ), .rise(tick_s));

  // next-state, strobe and counter logic
  always_comb begin
    field_oh_s  = {NFIELD{1'b0}};
    idx_nxt_s   = idx_r;
    rep_nxt_s   = rep_r;
    idle_nxt_s  = idle_r;
    inc_nxt_s   = {NFIELD{1'b0}};
    clr_nxt_s   = {NFIELD{1'b0}};
    timeout_s   = 1'b0;
    rep_fire_s  = 1'b0;

    for (int i = 0; i < NFIELD; i++) begin
      field_oh_s[i] = (idx_r == IDX_W'(adj_code(i)));
    end
    in_field_s = (idx_r != IDX_NORM);

    if (TOUT_TICKS != 0) begin
      timeout_s = in_field_s & tick_s & (idle_r == TOUT_LAST);
    end else begin
      timeout_s = 1'b0;
    end

    if (REP_DELAY != 0) begin
      rep_fire_s = in_field_s & SELECT & tick_s & (rep_r == REP_LAST);
    end else begin
      rep_fire_s = 1'b0;
    end

    // timeout beats a same-cycle MODE edge; out-of-range codes fall back to NORM
    if (timeout_s) begin
      idx_nxt_s = IDX_NORM;
    end else if (mode_rise_s) begin
      idx_nxt_s = (idx_r >= IDX_LAST) ? IDX_NORM : idx_r + IDX_W'(1'b1);
    end else begin
      idx_nxt_s = idx_r;
    end

    strobe_ok_s = in_field_s & ~timeout_s & ~mode_rise_s;
    if (strobe_ok_s && adj_rise_s) begin
      clr_nxt_s = field_oh_s;
    end else if (strobe_ok_s && (sel_rise_s || rep_fire_s)) begin
      inc_nxt_s = field_oh_s;
    end else begin
      clr_nxt_s = {NFIELD{1'b0}};
      inc_nxt_s = {NFIELD{1'b0}};
    end

    if ((idx_nxt_s != idx_r) || !SELECT || !in_field_s) begin
      rep_nxt_s = {REP_W{1'b0}};
    end else if (tick_s && (rep_r != REP_LAST)) begin
      rep_nxt_s = rep_r + REP_W'(1'b1);
    end else begin
      rep_nxt_s = rep_r;
    end

    // any user activity or increment restarts the idle window
    if ((idx_nxt_s == IDX_NORM) || mode_rise_s || sel_rise_s || adj_rise_s || (|inc_nxt_s)) begin
      idle_nxt_s = {TOUT_W{1'b0}};
    end else if (tick_s && (TOUT_TICKS != 0)) begin
      idle_nxt_s = idle_r + TOUT_W'(1'b1);
    end else begin
      idle_nxt_s = idle_r;
    end
  end

  // state, counters and strobe registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      idx_r  <= IDX_NORM;
      rep_r  <= {REP_W{1'b0}};
      idle_r <= {TOUT_W{1'b0}};
      inc_r  <= {NFIELD{1'b0}};
      clr_r  <= {NFIELD{1'b0}};
    end else begin
      idx_r  <= idx_nxt_s;
      rep_r  <= rep_nxt_s;
      idle_r <= idle_nxt_s;
      inc_r  <= inc_nxt_s;
      clr_r  <= clr_nxt_s;
    end
  end

  assign INC     = inc_r;
  assign CLR     = clr_r;
  assign ADJMODE = (idx_r != IDX_NORM);
  assign ON      = ~(field_oh_s & {NFIELD{SIG2HZ}});

endmodule

// File: tb/tb_adjust_sequencer.sv
// Self-checking bench for adjust_sequencer: directed scenarios with fixed
// expectations plus randomized traffic against a behavioural model.
module tb_adjust_sequencer;

  localparam int NF = 3;
  localparam int TT = 4;
  localparam int RD = 2;

  logic CLK = 1'b0;
  logic rst, mode, sel, adj, sig;
  logic [2:0] clr, inc, on;
  logic       adjmode;
  logic [0:0] clr1, inc1, on1;
  logic       adjmode1;
  logic [2:0] clr0, inc0, on0;
  logic       adjmode0;

  int pass_cnt = 0;
  int total_cnt = 0;

  int   m_idx, m_rep, m_idle;
  logic m_pm, m_ps, m_pa, m_pg;
  logic [2:0] m_inc, m_clr;

  always #5 CLK = ~CLK;

  adjust_sequencer #(.NFIELD(3), .TOUT_TICKS(4), .REP_DELAY(2)) dut (
    .CLK(CLK), .RST(rst), .SIG2HZ(sig), .MODE(mode), .SELECT(sel), .ADJUST(adj),
    .CLR(clr), .INC(inc), .ON(on), .ADJMODE(adjmode));

  adjust_sequencer #(.NFIELD(1), .TOUT_TICKS(4), .REP_DELAY(2)) dut_n1 (
    .CLK(CLK), .RST(rst), .SIG2HZ(sig), .MODE(mode), .SELECT(sel), .ADJUST(adj),
    .CLR(clr1), .INC(inc1), .ON(on1), .ADJMODE(adjmode1));

  adjust_sequencer #(.NFIELD(3), .TOUT_TICKS(0), .REP_DELAY(2)) dut_t0 (
    .CLK(CLK), .RST(rst), .SIG2HZ(sig), .MODE(mode), .SELECT(sel), .ADJUST(adj),
    .CLR(clr0), .INC(inc0), .ON(on0), .ADJMODE(adjmode0));

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; mode = 1'b0; sel = 1'b0; adj = 1'b0; sig = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic press_mode();
    mode = 1'b1; step();
    mode = 1'b0; step();
  endtask

  // Behavioural model: one call per clock edge with the inputs sampled there.
  task automatic model_clock(input logic r, input logic md, input logic sl,
                             input logic ad, input logic sg);
    logic me, se, ae, ge, in_f, tout, rfire;
    int   nidx;
    logic [2:0] one_v;
    one_v = 3'b001;
    if (r) begin
      m_idx = 0; m_rep = 0; m_idle = 0;
      m_inc = 3'b000; m_clr = 3'b000;
      m_pm = 1'b1; m_ps = 1'b1; m_pa = 1'b1; m_pg = 1'b1;
    end else begin
      me = md & ~m_pm; se = sl & ~m_ps; ae = ad & ~m_pa; ge = sg & ~m_pg;
      in_f  = (m_idx != 0);
      tout  = in_f && ge && (TT != 0) && (m_idle + 1 == TT);
      nidx  = tout ? 0 : (me ? (m_idx + 1) % (NF + 1) : m_idx);
      rfire = in_f && sl && ge && (RD != 0) && (m_rep == RD);
      m_inc = 3'b000; m_clr = 3'b000;
      if (in_f && !tout && !me) begin
        if (ae) m_clr = one_v << (m_idx - 1);
        else if (se || rfire) m_inc = one_v << (m_idx - 1);
      end
      if (!sl || !in_f || nidx != m_idx) m_rep = 0;
      else if (ge && m_rep < RD) m_rep = m_rep + 1;
      if (nidx == 0 || me || se || ae || m_inc != 3'b000) m_idle = 0;
      else if (ge) m_idle = m_idle + 1;
      m_idx = nidx;
      m_pm = md; m_ps = sl; m_pa = ad; m_pg = sg;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b0; sel = 1'b0; adj = 1'b0; sig = 1'b1;
    step();
    total_cnt++;
    if ({inc, clr, adjmode, on} !== {3'b000, 3'b000, 1'b0, 3'b111})
      $display("FAIL reset_state: got inc=%b clr=%b adjmode=%b on=%b, want 000 000 0 111", inc, clr, adjmode, on);
    else pass_cnt++;
    total_cnt++;
    if ({adjmode1, adjmode0} !== 2'b00)
      $display("FAIL reset_state_variants: got adjmode1=%b adjmode0=%b, want 0 0", adjmode1, adjmode0);
    else pass_cnt++;
    rst = 1'b0; sig = 1'b0;
    step();
  endtask

  task automatic test_mode_cycle();
    logic [2:0] one_v, exp_on;
    one_v = 3'b001;
    do_reset();
    sig = 1'b1;
    step();
    for (int k = 1; k <= 4; k++) begin
      mode = 1'b1; step();
      exp_on = (k == 4) ? 3'b111 : ~(one_v << (k - 1));
      total_cnt++;
      if ({adjmode, on, inc, clr} !== {(k != 4), exp_on, 3'b000, 3'b000})
        $display("FAIL mode_press_%0d: got adjmode=%b on=%b inc=%b clr=%b, want %b %b 000 000",
                 k, adjmode, on, inc, clr, (k != 4), exp_on);
      else pass_cnt++;
      mode = 1'b0; step();
      total_cnt++;
      if ({inc, clr} !== 6'b000000)
        $display("FAIL mode_release_%0d: got inc=%b clr=%b, want 000 000", k, inc, clr);
      else pass_cnt++;
    end
    sig = 1'b0;
  endtask

  task automatic test_inc_clr();
    do_reset();
    press_mode(); press_mode();
    sel = 1'b1; step();
    total_cnt++;
    if ({inc, clr} !== {3'b010, 3'b000})
      $display("FAIL select_inc: got inc=%b clr=%b, want 010 000", inc, clr);
    else pass_cnt++;
    step();
    total_cnt++;
    if (inc !== 3'b000) $display("FAIL select_width: got inc=%b, want 000", inc);
    else pass_cnt++;
    sel = 1'b0; step();
    adj = 1'b1; step();
    total_cnt++;
    if ({inc, clr} !== {3'b000, 3'b010})
      $display("FAIL adjust_clr: got inc=%b clr=%b, want 000 010", inc, clr);
    else pass_cnt++;
    step();
    total_cnt++;
    if (clr !== 3'b000) $display("FAIL adjust_width: got clr=%b, want 000", clr);
    else pass_cnt++;
    adj = 1'b0; step();
    sel = 1'b1; adj = 1'b1; step();
    total_cnt++;
    if ({inc, clr} !== {3'b000, 3'b010})
      $display("FAIL adjust_over_select: got inc=%b clr=%b, want 000 010", inc, clr);
    else pass_cnt++;
    sel = 1'b0; adj = 1'b0; step();
  endtask

  task automatic test_repeat();
    int pulses;
    pulses = 0;
    do_reset();
    press_mode();
    sel = 1'b1; step();
    total_cnt++;
    if (inc !== 3'b001) $display("FAIL repeat_press: got inc=%b, want 001", inc);
    else pass_cnt++;
    for (int e = 1; e <= 5; e++) begin
      sig = 1'b1; step();
      if (inc == 3'b001) pulses++;
      total_cnt++;
      if (inc !== ((e >= 3) ? 3'b001 : 3'b000))
        $display("FAIL repeat_edge_%0d: got inc=%b, want %b", e, inc, (e >= 3) ? 3'b001 : 3'b000);
      else pass_cnt++;
      sig = 1'b0; step();
      if (inc != 3'b000) pulses++;
    end
    total_cnt++;
    if (pulses !== 3) $display("FAIL repeat_count: got %0d pulses, want 3", pulses);
    else pass_cnt++;
    sel = 1'b0; step();
    sig = 1'b1; step();
    total_cnt++;
    if (inc !== 3'b000) $display("FAIL repeat_release: got inc=%b, want 000", inc);
    else pass_cnt++;
    sig = 1'b0; step();
  endtask

  task automatic test_timeout();
    do_reset();
    press_mode(); press_mode(); press_mode();
    for (int e = 1; e <= 4; e++) begin
      sig = 1'b1; step();
      total_cnt++;
      if (adjmode !== (e < 4))
        $display("FAIL timeout_edge_%0d: got adjmode=%b, want %b", e, adjmode, (e < 4));
      else pass_cnt++;
      sig = 1'b0; step();
    end
    do_reset();
    press_mode(); press_mode(); press_mode();
    for (int e = 1; e <= 7; e++) begin
      sig = 1'b1;
      if (e == 3) sel = 1'b1;
      step();
      if (e == 3) begin
        total_cnt++;
        if (inc !== 3'b100) $display("FAIL timeout_select_inc: got inc=%b, want 100", inc);
        else pass_cnt++;
      end
      total_cnt++;
      if (adjmode !== (e < 7))
        $display("FAIL timeout_restart_edge_%0d: got adjmode=%b, want %b", e, adjmode, (e < 7));
      else pass_cnt++;
      sig = 1'b0; sel = 1'b0; step();
    end
  endtask

  task automatic test_blink_and_reset();
    do_reset();
    press_mode(); press_mode();
    for (int n = 0; n < 3; n++) begin
      sig = 1'b1; #1;
      total_cnt++;
      if (on !== 3'b101) $display("FAIL blink_high_%0d: got on=%b, want 101", n, on);
      else pass_cnt++;
      step();
      sig = 1'b0; #1;
      total_cnt++;
      if (on !== 3'b111) $display("FAIL blink_low_%0d: got on=%b, want 111", n, on);
      else pass_cnt++;
      step();
    end
    rst = 1'b1; mode = 1'b1; step(); step();
    rst = 1'b0; step(); step();
    total_cnt++;
    if ({adjmode, adjmode1, adjmode0} !== 3'b000)
      $display("FAIL mode_held_reset: got adjmode=%b/%b/%b, want 0/0/0", adjmode, adjmode1, adjmode0);
    else pass_cnt++;
    mode = 1'b0; step();
    press_mode();
    sel = 1'b1; step();
    for (int e = 1; e <= 2; e++) begin
      sig = 1'b1; step();
      sig = 1'b0; step();
    end
    sig = 1'b1; rst = 1'b1; step();
    total_cnt++;
    if ({inc, adjmode} !== {3'b000, 1'b0})
      $display("FAIL reset_mid_repeat: got inc=%b adjmode=%b, want 000 0", inc, adjmode);
    else pass_cnt++;
    rst = 1'b0; sel = 1'b0; sig = 1'b0; step();
  endtask

  task automatic test_nfield1();
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      mode = 1'b1; step();
      total_cnt++;
      if ({adjmode1, inc1, clr1} !== {((k % 2) == 1), 1'b0, 1'b0})
        $display("FAIL nfield1_press_%0d: got adjmode=%b inc=%b clr=%b, want %b 0 0",
                 k, adjmode1, inc1, clr1, ((k % 2) == 1));
      else pass_cnt++;
      mode = 1'b0; step();
    end
    press_mode();
    sig = 1'b1; #1;
    total_cnt++;
    if (on1 !== 1'b0) $display("FAIL nfield1_blink: got on=%b, want 0", on1);
    else pass_cnt++;
    sig = 1'b0; step();
  endtask

  task automatic test_tout0();
    do_reset();
    press_mode();
    for (int n = 0; n < 100; n++) begin
      sig = 1'b1; step();
      sig = 1'b0; step();
    end
    sig = 1'b1; #1;
    total_cnt++;
    if ({adjmode0, on0, inc0, clr0} !== {1'b1, 3'b110, 3'b000, 3'b000})
      $display("FAIL no_timeout: got adjmode=%b on=%b inc=%b clr=%b, want 1 110 000 000",
               adjmode0, on0, inc0, clr0);
    else pass_cnt++;
    sig = 1'b0; step();
  endtask

  task automatic test_random();
    logic [2:0] exp_on;
    int slow;
    mode = 1'b0; sel = 1'b0; adj = 1'b0; sig = 1'b0;
    for (int c = 0; c < 1200; c++) begin
      slow = (c < 500) ? 1 : 4;
      rst = (c < 2) || ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 6 * slow - 1) == 0) mode = ~mode;
      if ($urandom_range(0, 5 * slow - 1) == 0) sel = ~sel;
      if ($urandom_range(0, 8 * slow - 1) == 0) adj = ~adj;
      if ($urandom_range(0, 2) == 0) sig = ~sig;
      model_clock(rst, mode, sel, adj, sig);
      step();
      exp_on = 3'b111;
      if (m_idx != 0 && sig) exp_on[m_idx - 1] = 1'b0;
      total_cnt++;
      if ({inc, clr, adjmode, on} !== {m_inc, m_clr, (m_idx != 0), exp_on})
        $display("FAIL random_cycle_%0d: got inc=%b clr=%b adjmode=%b on=%b, want %b %b %b %b",
                 c, inc, clr, adjmode, on, m_inc, m_clr, (m_idx != 0), exp_on);
      else pass_cnt++;
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; sel = 1'b0; adj = 1'b0; sig = 1'b0;
    test_reset();
    test_mode_cycle();
    test_inc_clr();
    test_repeat();
    test_timeout();
    test_blink_and_reset();
    test_nfield1();
    test_tout0();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
